// File: rtl/de1_blinker_nios2_proc_debug_scan_master.sv
// Virtual-JTAG scan initiator for the Nios II debug slave: takes one IR/DR command,
// runs UIR -> CDR -> SDR -> UDR with a divided tck, and returns the captured DR.
module de1_blinker_nios2_proc_debug_scan_master #(
   parameter int DR_WIDTH = 38,
   parameter int IR_WIDTH = 2,
   parameter int TCK_DIV  = 4
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                cmd_valid,
   output logic                cmd_ready,
   input  logic [IR_WIDTH-1:0] cmd_ir,
   input  logic [DR_WIDTH-1:0] cmd_data,
   output logic                rsp_valid,
   input  logic                rsp_ready,
   output logic [DR_WIDTH-1:0] rsp_data,
   output logic                vji_tck,
   output logic                vji_tdi,
   input  logic                vji_tdo,
   output logic [IR_WIDTH-1:0] vji_ir_in,
   output logic                vji_rti,
   output logic                vji_uir,
   output logic                vji_cdr,
   output logic                vji_sdr,
   output logic                vji_udr
);

   typedef enum logic [2:0] {S_IDLE, S_UIR, S_CDR, S_SDR, S_UDR, S_RSP} state_t;

   localparam int CW = 9;
   localparam int BW = $clog2(DR_WIDTH + 1);
   localparam logic [CW-1:0] HALF     = CW'(TCK_DIV);
   localparam logic [CW-1:0] LAST     = CW'(2 * TCK_DIV - 1);
   localparam logic [BW-1:0] BIT_LAST = BW'(DR_WIDTH - 1);

   state_t              state_q, state_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic [BW-1:0]       bit_q, bit_d;
   logic [DR_WIDTH-1:0] tx_q, tx_d;
   logic [DR_WIDTH-1:0] cap_q, cap_d;
   logic [IR_WIDTH-1:0] ir_q, ir_d;
   logic                cmd_ready_q, cmd_ready_d;
   logic                rsp_valid_q, rsp_valid_d;
   logic                tck_q, tck_d;
   logic                tdi_q, tdi_d;
   logic                rti_q, rti_d;
   logic                uir_q, uir_d;
   logic                cdr_q, cdr_d;
   logic                sdr_q, sdr_d;
   logic                udr_q, udr_d;
   logic                active;
   logic                period_end;

   always_comb begin
      state_d    = state_q;
      cnt_d      = '0;
      bit_d      = bit_q;
      tx_d       = tx_q;
      cap_d      = cap_q;
      ir_d       = ir_q;
      active     = (state_q == S_UIR) || (state_q == S_CDR) ||
                   (state_q == S_SDR) || (state_q == S_UDR);
      period_end = active && (cnt_q == LAST);

      if (active && !period_end)
         cnt_d = cnt_q + CW'(1);

      case (state_q)
         S_IDLE: begin
            if (cmd_valid && cmd_ready_q) begin
               ir_d    = cmd_ir;
               tx_d    = cmd_data;
               cap_d   = '0;
               bit_d   = '0;
               state_d = S_UIR;
            end
         end
         S_UIR: if (period_end) state_d = S_CDR;
         S_CDR: if (period_end) state_d = S_SDR;
         S_SDR: begin
            // tdo is sampled on the clk edge that raises tck, before the slave shifts
            if (cnt_q == HALF)
               cap_d = {vji_tdo, cap_q[DR_WIDTH-1:1]};
            if (period_end) begin
               tx_d = tx_q >> 1;
               if (bit_q == BIT_LAST)
                  state_d = S_UDR;
               else
                  bit_d = bit_q + BW'(1);
            end
         end
         S_UDR: if (period_end) state_d = S_RSP;
         S_RSP: if (rsp_valid_q && rsp_ready) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      // Strobes and tck trail the state by one clk so they land on period boundaries;
      // cmd_ready and the rsp_valid fall follow the next state so handshakes stay exact.
      cmd_ready_d = (state_d == S_IDLE);
      rsp_valid_d = (state_q == S_RSP) && (state_d == S_RSP);
      tck_d       = active && (cnt_q >= HALF);
      tdi_d       = (cnt_q == '0) ? ((state_q == S_SDR) && tx_q[0]) : tdi_q;
      rti_d       = (state_q == S_IDLE) || (state_d == S_IDLE);
      uir_d       = (state_q == S_UIR);
      cdr_d       = (state_q == S_CDR);
      sdr_d       = (state_q == S_SDR);
      udr_d       = (state_q == S_UDR);
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         bit_q       <= '0;
         tx_q        <= '0;
         cap_q       <= '0;
         ir_q        <= '0;
         cmd_ready_q <= 1'b1;
         rsp_valid_q <= 1'b0;
         tck_q       <= 1'b0;
         tdi_q       <= 1'b0;
         rti_q       <= 1'b1;
         uir_q       <= 1'b0;
         cdr_q       <= 1'b0;
         sdr_q       <= 1'b0;
         udr_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         bit_q       <= bit_d;
         tx_q        <= tx_d;
         cap_q       <= cap_d;
         ir_q        <= ir_d;
         cmd_ready_q <= cmd_ready_d;
         rsp_valid_q <= rsp_valid_d;
         tck_q       <= tck_d;
         tdi_q       <= tdi_d;
         rti_q       <= rti_d;
         uir_q       <= uir_d;
         cdr_q       <= cdr_d;
         sdr_q       <= sdr_d;
         udr_q       <= udr_d;
      end
   end

   assign cmd_ready = cmd_ready_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_data  = cap_q;
   assign vji_tck   = tck_q;
   assign vji_tdi   = tdi_q;
   assign vji_ir_in = ir_q;
   assign vji_rti   = rti_q;
   assign vji_uir   = uir_q;
   assign vji_cdr   = cdr_q;
   assign vji_sdr   = sdr_q;
   assign vji_udr   = udr_q;

endmodule

// File: tb/tb_de1_blinker_nios2_proc_debug_scan_master.sv
// Bench: a behavioural 38-bit virtual-JTAG slave (shift on tck rise while sdr) is the
// reference; a scan must return the slave's old contents and leave the command data in it.
module tb_de1_blinker_nios2_proc_debug_scan_master;
   localparam int DW = 38;
   localparam int IW = 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic reset_n = 1'b0;
   logic rsp_ready = 1'b1;

   logic          cmd_valid = 1'b1, cmd_ready, rsp_valid, tck, tdi, tdo, rti, uir, cdr, sdr, udr;
   logic [IW-1:0] cmd_ir = '0, ir_in;
   logic [DW-1:0] cmd_data = '0, rsp_data;

   logic          cmd_valid1 = 1'b0, cmd_ready1, rsp_valid1, tck1, tdi1, tdo1, rti1, uir1, cdr1, sdr1, udr1;
   logic [IW-1:0] cmd_ir1 = '0, ir_in1;
   logic [DW-1:0] cmd_data1 = '0, rsp_data1;

   de1_blinker_nios2_proc_debug_scan_master #(.DR_WIDTH(DW), .IR_WIDTH(IW), .TCK_DIV(4)) dut (
      .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_ir(cmd_ir), .cmd_data(cmd_data), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_data(rsp_data), .vji_tck(tck), .vji_tdi(tdi), .vji_tdo(tdo), .vji_ir_in(ir_in),
      .vji_rti(rti), .vji_uir(uir), .vji_cdr(cdr), .vji_sdr(sdr), .vji_udr(udr));

   de1_blinker_nios2_proc_debug_scan_master #(.DR_WIDTH(DW), .IR_WIDTH(IW), .TCK_DIV(1)) dut1 (
      .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid1), .cmd_ready(cmd_ready1),
      .cmd_ir(cmd_ir1), .cmd_data(cmd_data1), .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready),
      .rsp_data(rsp_data1), .vji_tck(tck1), .vji_tdi(tdi1), .vji_tdo(tdo1), .vji_ir_in(ir_in1),
      .vji_rti(rti1), .vji_uir(uir1), .vji_cdr(cdr1), .vji_sdr(sdr1), .vji_udr(udr1));

   int vecs = 0, errs = 0, cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // slave models: sample tck in the clk domain, shift one clk after each tck rise
   logic [DW-1:0] slave, slave_pre, slave1, slave1_pre;
   logic slave_load = 1'b0, slave1_load = 1'b0, tdo_fixed = 1'b0, tdo_val = 1'b0;
   logic tck_prev = 1'b0, tck1_prev = 1'b0;
   int rises = 0, sdr_rises = 0, rises1 = 0, last_rise1 = 0, p1_err = 0;

   always @(posedge clk) begin
      tck_prev <= tck;
      if (slave_load) slave <= slave_pre;
      else if (tck && !tck_prev && sdr) slave <= {tdi, slave[DW-1:1]};
      if (tck && !tck_prev) begin
         rises <= rises + 1;
         if (sdr) sdr_rises <= sdr_rises + 1;
      end
   end
   assign tdo = tdo_fixed ? tdo_val : slave[0];

   always @(posedge clk) begin
      tck1_prev <= tck1;
      if (slave1_load) slave1 <= slave1_pre;
      else if (tck1 && !tck1_prev && sdr1) slave1 <= {tdi1, slave1[DW-1:1]};
      if (tck1 && !tck1_prev) begin
         rises1 <= rises1 + 1;
         if (sdr1 && (cyc - last_rise1 != 2)) p1_err <= p1_err + 1;
         last_rise1 <= cyc;
      end
   end
   assign tdo1 = slave1[0];

   // protocol monitor on the default instance: strobe exclusivity, tdi idle, strobe order
   logic mon_en = 1'b0;
   int onehot_err = 0, tdi_err = 0;
   logic [31:0] seq = '0;
   logic [3:0] last_code = '0;
   always @(negedge clk) begin
      if (mon_en) begin
         logic [3:0] code;
         int n;
         n = int'(rti) + int'(uir) + int'(cdr) + int'(sdr) + int'(udr);
         if (rsp_valid ? (n != 0) : (n != 1)) onehot_err <= onehot_err + 1;
         if (!sdr && tdi) tdi_err <= tdi_err + 1;
         code = rsp_valid ? 4'd5 : rti ? 4'd0 : uir ? 4'd1 : cdr ? 4'd2 : sdr ? 4'd3 : 4'd4;
         if (code != last_code) begin
            seq <= {seq[27:0], code};
            last_code <= code;
         end
      end
   end

   task automatic issue0(input logic [IW-1:0] ir, input logic [DW-1:0] d, output int a);
      @(negedge clk);
      cmd_ir = ir; cmd_data = d; cmd_valid = 1'b1;
      for (int i = 0; i < 200 && cmd_ready !== 1'b1; i++) @(negedge clk);
      vecs++;
      if (cmd_ready !== 1'b1) begin errs++; $display("FAIL accept0: cmd_ready=%b required 1", cmd_ready); end
      @(posedge clk); #1;
      a = cyc; cmd_valid = 1'b0; cmd_ir = ~ir; cmd_data = ~d;
   endtask

   task automatic issue1(input logic [IW-1:0] ir, input logic [DW-1:0] d, output int a);
      @(negedge clk);
      cmd_ir1 = ir; cmd_data1 = d; cmd_valid1 = 1'b1;
      for (int i = 0; i < 200 && cmd_ready1 !== 1'b1; i++) @(negedge clk);
      vecs++;
      if (cmd_ready1 !== 1'b1) begin errs++; $display("FAIL accept1: cmd_ready=%b required 1", cmd_ready1); end
      @(posedge clk); #1;
      a = cyc; cmd_valid1 = 1'b0; cmd_ir1 = ~ir; cmd_data1 = ~d;
   endtask

   task automatic wait_rsp0(input int a, output int lat);
      lat = -1;
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         if (rsp_valid === 1'b1) begin lat = cyc - a; break; end
      end
   endtask

   task automatic wait_rsp1(input int a, output int lat);
      lat = -1;
      for (int i = 0; i < 1000; i++) begin
         @(negedge clk);
         if (rsp_valid1 === 1'b1) begin lat = cyc - a; break; end
      end
   endtask

   function automatic logic [DW-1:0] rnd38();
      logic [63:0] t;
      t = {$urandom(), $urandom()};
      return t[DW-1:0];
   endfunction

   task automatic test_reset();
      int r0;
      reset_n = 1'b0; cmd_valid = 1'b1;
      r0 = rises;
      repeat (3) @(negedge clk);
      vecs++;
      if ({cmd_ready, rsp_valid, tck, tdi, rti, uir, cdr, sdr, udr} !== 9'b100010000) begin
         errs++; $display("FAIL reset_ctl: got %b required 100010000", {cmd_ready, rsp_valid, tck, tdi, rti, uir, cdr, sdr, udr});
      end
      vecs++;
      if ({rsp_data, ir_in} !== '0) begin errs++; $display("FAIL reset_data: rsp_data=%h ir_in=%b required 0", rsp_data, ir_in); end
      vecs++;
      if (rises != r0) begin errs++; $display("FAIL reset_tck: %0d edges required 0", rises - r0); end
      cmd_valid = 1'b0;
      reset_n = 1'b1;
      @(negedge clk);
      mon_en = 1'b1;
   endtask

   task automatic test_const_tdo();
      int a, lat, r0, s0;
      logic t4, t5;
      tdo_fixed = 1'b1; tdo_val = 1'b1; rsp_ready = 1'b1;
      r0 = rises; s0 = sdr_rises;
      issue0(2'b01, '0, a);
      @(negedge clk);
      vecs++;
      if ({cmd_ready, rti, uir} !== 3'b010) begin errs++; $display("FAIL cycle0: ready/rti/uir=%b required 010", {cmd_ready, rti, uir}); end
      @(negedge clk);
      vecs++;
      if ({ir_in, rti, uir} !== 4'b0101) begin errs++; $display("FAIL cycle1: ir/rti/uir=%b required 0101", {ir_in, rti, uir}); end
      repeat (3) @(negedge clk);
      t4 = tck;
      @(negedge clk);
      t5 = tck;
      vecs++;
      if ({t4, t5} !== 2'b01) begin errs++; $display("FAIL tck_first_rise: tck@4,5=%b required 01", {t4, t5}); end
      wait_rsp0(a, lat);
      vecs++;
      if (lat != 329) begin errs++; $display("FAIL const_latency: %0d required 329", lat); end
      vecs++;
      if (rsp_data !== 38'h3F_FFFF_FFFF) begin errs++; $display("FAIL const_data: %h required 3fffffffff", rsp_data); end
      vecs++;
      if (rises - r0 != DW + 3 || sdr_rises - s0 != DW) begin
         errs++; $display("FAIL tck_count: total %0d sdr %0d required %0d %0d", rises - r0, sdr_rises - s0, DW + 3, DW);
      end
      @(negedge clk);
      vecs++;
      if ({cmd_ready, rsp_valid, rti, ir_in} !== 5'b10101) begin
         errs++; $display("FAIL const_done: ready/valid/rti/ir=%b required 10101", {cmd_ready, rsp_valid, rti, ir_in});
      end
      tdo_fixed = 1'b0;
   endtask

   task automatic test_slave_random();
      int a, lat;
      logic [DW-1:0] pre, d;
      logic [IW-1:0] ir;
      rsp_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         pre = (k == 0) ? 38'h2A_5A5A_5A5A : rnd38();
         d   = (k == 0) ? 38'h15_A5A5_A5A5 : rnd38();
         ir  = IW'($urandom_range(0, 3));
         @(negedge clk); slave_pre = pre; slave_load = 1'b1;
         @(negedge clk); slave_load = 1'b0;
         issue0(ir, d, a);
         wait_rsp0(a, lat);
         vecs++;
         if (lat != 329) begin errs++; $display("FAIL slave_latency[%0d]: %0d required 329", k, lat); end
         vecs++;
         if (rsp_data !== pre) begin errs++; $display("FAIL slave_rsp[%0d]: %h required %h", k, rsp_data, pre); end
         vecs++;
         if (slave !== d) begin errs++; $display("FAIL slave_end[%0d]: %h required %h", k, slave, d); end
         vecs++;
         if (ir_in !== ir) begin errs++; $display("FAIL slave_ir[%0d]: %b required %b", k, ir_in, ir); end
         @(negedge clk); #1;
         vecs++;
         if (seq[23:0] !== 24'h123450) begin errs++; $display("FAIL strobe_order[%0d]: %h required 123450", k, seq[23:0]); end
      end
   endtask

   task automatic test_backpressure();
      int a, lat, bad;
      logic [DW-1:0] pre, snap;
      pre = rnd38();
      rsp_ready = 1'b0;
      @(negedge clk); slave_pre = pre; slave_load = 1'b1;
      @(negedge clk); slave_load = 1'b0;
      issue0(2'b10, rnd38(), a);
      wait_rsp0(a, lat);
      snap = rsp_data;
      vecs++;
      if (lat != 329 || snap !== pre) begin errs++; $display("FAIL bp_rsp: lat %0d data %h required 329 %h", lat, snap, pre); end
      bad = 0;
      repeat (50) begin
         @(negedge clk);
         if (rsp_valid !== 1'b1 || rsp_data !== snap || cmd_ready !== 1'b0 || tck !== 1'b0) bad++;
      end
      vecs++;
      if (bad != 0) begin errs++; $display("FAIL bp_hold: %0d unstable cycles required 0", bad); end
      rsp_ready = 1'b1;
      @(negedge clk);
      vecs++;
      if ({cmd_ready, rsp_valid} !== 2'b10) begin errs++; $display("FAIL bp_release: ready/valid=%b required 10", {cmd_ready, rsp_valid}); end
   endtask

   task automatic test_reset_mid_sdr();
      int a, lat, s0, seen;
      logic [DW-1:0] pre, d;
      rsp_ready = 1'b1;
      s0 = sdr_rises;
      issue0(2'b11, rnd38(), a);
      for (int i = 0; i < 2000 && sdr_rises - s0 < 10; i++) @(negedge clk);
      reset_n = 1'b0;
      @(negedge clk);
      vecs++;
      if ({cmd_ready, rsp_valid, tck, tdi, rti, uir, cdr, sdr, udr} !== 9'b100010000 || rsp_data !== '0 || ir_in !== '0) begin
         errs++; $display("FAIL abort_reset: ctl %b data %h ir %b required 100010000 0 0",
                          {cmd_ready, rsp_valid, tck, tdi, rti, uir, cdr, sdr, udr}, rsp_data, ir_in);
      end
      reset_n = 1'b1;
      seen = 0;
      repeat (400) begin
         @(negedge clk);
         if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) seen++;
      end
      vecs++;
      if (seen != 0) begin errs++; $display("FAIL abort_no_rsp: %0d bad cycles required 0", seen); end
      pre = rnd38(); d = rnd38();
      @(negedge clk); slave_pre = pre; slave_load = 1'b1;
      @(negedge clk); slave_load = 1'b0;
      issue0(2'b01, d, a);
      wait_rsp0(a, lat);
      vecs++;
      if (lat != 329 || rsp_data !== pre || slave !== d) begin
         errs++; $display("FAIL after_abort: lat %0d rsp %h slave %h required 329 %h %h", lat, rsp_data, slave, pre, d);
      end
      @(negedge clk); #1;
      vecs++;
      if (onehot_err != 0 || tdi_err != 0) begin
         errs++; $display("FAIL protocol: onehot %0d tdi %0d required 0 0", onehot_err, tdi_err);
      end
   endtask

   task automatic test_back_to_back();
      int a1, a2, lat1, lat2, r0;
      logic [DW-1:0] pre, da, db;
      pre = rnd38(); da = rnd38(); db = rnd38();
      rsp_ready = 1'b1;
      @(negedge clk); slave1_pre = pre; slave1_load = 1'b1;
      @(negedge clk); slave1_load = 1'b0;
      r0 = rises1;
      issue1(2'b10, da, a1);
      wait_rsp1(a1, lat1);
      vecs++;
      if (lat1 != 83 || rsp_data1 !== pre) begin errs++; $display("FAIL b2b_first: lat %0d data %h required 83 %h", lat1, rsp_data1, pre); end
      issue1(2'b01, db, a2);
      vecs++;
      if (a2 - a1 != 85) begin errs++; $display("FAIL b2b_gap: %0d required 85", a2 - a1); end
      wait_rsp1(a2, lat2);
      vecs++;
      if (lat2 != 83 || rsp_data1 !== da) begin errs++; $display("FAIL b2b_second: lat %0d data %h required 83 %h", lat2, rsp_data1, da); end
      @(negedge clk);
      vecs++;
      if (slave1 !== db || ir_in1 !== 2'b01) begin errs++; $display("FAIL b2b_slave: %h ir %b required %h 01", slave1, ir_in1, db); end
      vecs++;
      if (rises1 - r0 != 2 * (DW + 3) || p1_err != 0) begin
         errs++; $display("FAIL b2b_tck: edges %0d period errs %0d required %0d 0", rises1 - r0, p1_err, 2 * (DW + 3));
      end
   endtask

   initial begin
      test_reset();
      test_const_tdo();
      test_slave_random();
      test_backpressure();
      test_reset_mid_sdr();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end
endmodule
